// File: rtl/instr_fetch.sv
// instr_fetch: streams 12-bit instruction words from a small program memory
// into the ALU stage. Execution starts at PC 0 and stops when a HALT word
// (opcode 4'hD) is issued. The program memory can be loaded only while idle
// or halted.
//
// Optional feature: define FETCH_STEP_EN to add the `step` input. In that
// build a RUN cycle fetches only when step=1 (single-step mode).
module instr_fetch #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [11:0]   prog_data,
  input  logic          start,
  input  logic          stall,
`ifdef FETCH_STEP_EN
  input  logic          step,
`endif
  output logic [11:0]   instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          running,
  output logic          halted
);

  localparam logic [3:0] OpHalt = 4'hD;

  // The PC wraps by natural overflow, so the memory must exactly fill the
  // address space.
  if (DEPTH != (1 << AW)) begin : g_depth_check
    $error("instr_fetch: DEPTH must equal 2**AW");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalted
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [11:0]   instr_q, instr_d;
  logic          valid_q, valid_d;

  logic [11:0]   mem_q [DEPTH];
  logic [11:0]   fetch_word;
  logic          fetch_en;
  logic          mem_we;

  assign fetch_word = mem_q[pc_q];

`ifdef FETCH_STEP_EN
  assign fetch_en = ~stall & step;
`else
  assign fetch_en = ~stall;
`endif

  // Loads are locked out while running and while reset is asserted.
  assign mem_we = prog_we & ~reset & (state_q != StRun);

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state and next-output decode for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          valid_d = 1'b0;
        end else if ((state_q == StHalted) && !stall) begin
          // The HALT word stays presented until the ALU stage takes it.
          valid_d = 1'b0;
        end
      end
      StRun: begin
        if (fetch_en) begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          pc_d    = pc_q + AW'(1);
          if (fetch_word[11:8] == OpHalt) begin
            state_d = StHalted;
          end
        end else if (!stall) begin
          // Only reachable in single-step mode: an unstepped cycle issues nothing.
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign running     = (state_q == StRun);
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. The stimulus process drives one cycle at a
// time, advances a behavioural model and queues the expected post-edge outputs;
// an independent monitor pops and compares on every falling edge.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
`ifdef FETCH_STEP_EN
  localparam bit StepMode = 1'b1;
`else
  localparam bit StepMode = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, prog_we, start, stall, step;
  logic [AW-1:0] prog_addr;
  logic [11:0]   prog_data;
  logic [11:0]   instr;
  logic          instr_valid, running, halted;
  logic [AW-1:0] pc;

  instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .stall       (stall),
`ifdef FETCH_STEP_EN
    .step        (step),
`endif
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .running     (running),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]   instr;
    logic          valid;
    logic [AW-1:0] pc;
    logic          running;
    logic          halted;
  } snap_t;

  snap_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    mon_cyc = 0;

  // Behavioural model: the machine's observable state in plain terms.
  typedef enum int {MIdle, MRun, MHalted} mmode_t;
  mmode_t      m_mode = MIdle;
  int          m_pc = 0;
  logic [11:0] m_instr = '0;
  bit          m_valid = 1'b0;
  logic [11:0] m_mem [DEPTH];

  task automatic model_step(input bit r, input bit st, input bit sl, input bit we,
                            input int a, input logic [11:0] d, input bit sp);
    if (r) begin
      m_mode  = MIdle;
      m_pc    = 0;
      m_instr = '0;
      m_valid = 1'b0;
    end else begin
      if (we && m_mode != MRun) m_mem[a] = d;
      if (m_mode != MRun) begin
        if (st) begin
          m_mode  = MRun;
          m_pc    = 0;
          m_valid = 1'b0;
        end else if (m_mode == MHalted && !sl) begin
          m_valid = 1'b0;
        end
      end else if (!sl && (!StepMode || sp)) begin
        m_instr = m_mem[m_pc];
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % DEPTH;
        if (m_instr[11:8] == 4'hD) m_mode = MHalted;
      end else if (!sl) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the outcome, then let the edge happen.
  task automatic tick(input bit r, input bit st, input bit sl, input bit we,
                      input int a, input logic [11:0] d, input bit sp);
    snap_t e;
    reset     = r;
    start     = st;
    stall     = sl;
    prog_we   = we;
    prog_addr = AW'(a);
    prog_data = d;
    step      = sp;
    model_step(r, st, sl, we, a, d, sp);
    e.instr   = m_instr;
    e.valid   = m_valid;
    e.pc      = AW'(m_pc);
    e.running = (m_mode == MRun);
    e.halted  = (m_mode == MHalted);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit sl);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, sl, 1'b0, 0, 12'h000, 1'b1);
  endtask

  task automatic write_word(input int a, input logic [11:0] d);
    tick(1'b0, 1'b0, 1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic do_start();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b1);
  endtask

  // Monitor: compare every presented output against the queued prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      e = exp_q.pop_front();
      a = {instr, instr_valid, pc, running, halted};
      n_cmp++;
      mon_cyc++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cyc%0d: got instr=%h valid=%b pc=%0d running=%b halted=%b; want instr=%h valid=%b pc=%0d running=%b halted=%b",
                 mon_cyc, a.instr, a.valid, a.pc, a.running, a.halted,
                 e.instr, e.valid, e.pc, e.running, e.halted);
      end
    end
  end

  initial begin
    logic [11:0] w;
    int guard;

    // Reset held for two cycles.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);

    // Streaming program 741, 0C0, D00; remaining words never HALT.
    write_word(0, 12'h741);
    write_word(1, 12'h0C0);
    write_word(2, 12'hD00);
    for (int i = 3; i < DEPTH; i++) begin
      w = 12'($urandom);
      if (w[11:8] == 4'hD) w[11:8] = 4'h0;
      write_word(i, w);
    end
    do_start();
    run(6, 1'b0);

    // Stall for three cycles while 741 is presented, then hold the HALT word.
    do_start();
    run(1, 1'b0);
    run(3, 1'b1);
    run(2, 1'b0);
    run(2, 1'b1);
    run(2, 1'b0);

    // Wrap program with no HALT; one write attempted mid-run must be ignored.
    for (int i = 0; i < DEPTH; i++) write_word(i, 12'h100 + 12'(i));
    do_start();
    run(5, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8, 12'hD55, 1'b1);
    run(16, 1'b0);

    // Reset while running at pc 5, then restart from word 0.
    guard = 0;
    while (m_pc != 5 && guard < 2 * DEPTH) begin
      run(1, 1'b0);
      guard++;
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b1);
    run(2, 1'b0);
    do_start();
    run(DEPTH + 2, 1'b0);

`ifdef FETCH_STEP_EN
    // Single step: pulses on cycles 3 and 7 after start issue exactly two words.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 12'h000, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b0);
    for (int c = 1; c <= 9; c++)
      tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 12'h000, (c == 3) || (c == 7));
`endif

    // Randomised traffic; HALT words appear naturally through random writes.
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 30,
           int'($urandom_range(0, DEPTH - 1)), 12'($urandom),
           $urandom_range(0, 99) < 60);
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
